// File: rtl/user_module_prog_clkdiv.sv
// Programmable clock divider on the 8-in/8-out user-module frame: loadable ratio R,
// divisor D=R+1, with near-50% div, terminal-count pulse, exact-50% toggle and live count.
module user_module_prog_clkdiv #(
  parameter int DIV_WIDTH   = 5,
  parameter int RESET_RATIO = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [DIV_WIDTH-1:0] RST_R = DIV_WIDTH'(RESET_RATIO);

  logic                 clk, rst, ld_pin;
  logic [DIV_WIDTH-1:0] ratio_in;

  assign clk      = io_in[0];
  assign rst      = io_in[1];
  assign ld_pin   = io_in[2];
  assign ratio_in = io_in[3 +: DIV_WIDTH];

  logic [DIV_WIDTH-1:0]   r_q, r_d, cnt_q, cnt_d;
  logic                   div_q, div_d, tc_q, tc_d, tog_q, tog_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ld_prev_q, ld_rise;
  logic [DIV_WIDTH:0]     half;

  always_comb begin
    sync_d    = '0;
    sync_d[0] = ld_pin;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    ld_rise = sync_q[SYNC_STAGES-1] & ~ld_prev_q;

    r_d   = r_q;
    cnt_d = cnt_q;
    tog_d = tog_q;
    // A load truncates the current period; tog_q holds even if this edge would have wrapped.
    if (ld_rise) begin
      r_d   = ratio_in;
      cnt_d = '0;
    end else if (cnt_q == r_q) begin
      cnt_d = '0;
      tog_d = ~tog_q;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end

    // Outputs are registered from next-state values so they line up with cnt_q.
    half  = ({1'b0, r_d} + (DIV_WIDTH+1)'(2)) >> 1;
    div_d = ({1'b0, cnt_d} < half);
    tc_d  = (cnt_d == r_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= RST_R;
      cnt_q     <= '0;
      tog_q     <= 1'b0;
      div_q     <= 1'b1;
      tc_q      <= (RESET_RATIO == 0);
      sync_q    <= '0;
      ld_prev_q <= 1'b0;
    end else begin
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      tog_q     <= tog_d;
      div_q     <= div_d;
      tc_q      <= tc_d;
      sync_q    <= sync_d;
      ld_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  logic [4:0] cnt_ext;
  always_comb begin
    cnt_ext                = '0;
    cnt_ext[DIV_WIDTH-1:0] = cnt_q;
  end

  assign io_out = {cnt_ext, tog_q, tc_q, div_q};

endmodule

// File: tb/tb_user_module_prog_clkdiv.sv
// Directed bench for user_module_prog_clkdiv; expected bytes from hand-derived
// period formulas (cnt=i mod D, tog flips per wrap, div=cnt<ceil(D/2), tc=cnt==R).
module tb_user_module_prog_clkdiv;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld  = 1'b0;
  logic [4:0] data = '0;
  logic [7:0] io_in, io_out;

  assign io_in = {data, ld, rst, clk};

  user_module_prog_clkdiv dut (.io_in(io_in), .io_out(io_out));

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%b exp=%b (cnt=%0d tog=%b tc=%b div=%b expected)",
               tag, got, exp, exp[7:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] expv(input int r, input int i, input logic tog0);
    int c, w;
    logic [4:0] c5;
    c  = i % (r + 1);
    w  = i / (r + 1);
    c5 = 5'(c);
    return {c5, tog0 ^ logic'(w & 1), logic'(c == r), logic'(c < (r + 2) / 2)};
  endfunction

  // Runs n edges from cnt=0 with ratio r and known starting tog.
  task automatic run_chk(input string tag, input int r, input int n, input logic tog0);
    for (int i = 1; i <= n; i++) begin
      tick();
      chk(tag, io_out, expv(r, i, tog0));
    end
  endtask

  // Reset, then release with load high: load lands on the 3rd edge, leaving cnt=0, tog=0.
  task automatic start(input logic [4:0] r, input logic hold);
    rst = 1'b1; ld = 1'b0;
    tick();
    chk("rst", io_out, 8'h03);
    rst = 1'b0; ld = 1'b1; data = r;
    tick();
    if (!hold) ld = 1'b0;
    tick();
    chk("pre_ld", io_out, 8'h03);
    tick();
    chk("ld_lat", io_out, {5'd0, 1'b0, logic'(r == 5'd0), 1'b1});
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("rst_val", io_out, 8'h03);
    rst = 1'b0;
    run_chk("r0_legacy", 0, 8, 1'b0);

    start(5'd3, 1'b0);
    run_chk("r3", 3, 16, 1'b0);

    start(5'd4, 1'b0);
    run_chk("r4", 4, 20, 1'b0);

    start(5'd31, 1'b0);
    run_chk("r31", 31, 130, 1'b0);

    // Pin held 20 cycles with data changed mid-hold: only the first edge loads.
    start(5'd5, 1'b1);
    for (int i = 1; i <= 30; i++) begin
      if (i == 3)  data = 5'd9;
      if (i == 18) ld = 1'b0;
      tick();
      chk("hold", io_out, expv(5, i, 1'b0));
    end

    // Load lands on the edge that would wrap cnt 5->0: tog must not flip.
    start(5'd5, 1'b0);
    tick(); tick(); tick();
    chk("mid_cnt3", io_out, {5'd3, 1'b0, 1'b0, 1'b0});
    data = 5'd2; ld = 1'b1;
    tick();
    ld = 1'b0;
    tick();
    chk("mid_cnt5", io_out, {5'd5, 1'b0, 1'b1, 1'b0});
    tick();
    chk("mid_ld", io_out, {5'd0, 1'b0, 1'b0, 1'b1});
    run_chk("r2", 2, 9, 1'b0);

    // Reset one edge after the pin rises discards the pending load.
    data = 5'd7; ld = 1'b1;
    tick();
    rst = 1'b1; ld = 1'b0;
    tick();
    chk("rst_pend", io_out, 8'h03);
    rst = 1'b0;
    run_chk("no_ld", 0, 8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
